// File: rtl/druaga_rom_loader_if.sv
// HPS download stream: byte strobe, address and data toward the loader,
// with a back-pressure wait returned to the source.
interface druaga_rom_loader_if;
  logic        DL_ACTIVE;
  logic        DL_WR;
  logic [24:0] DL_ADDR;
  logic [7:0]  DL_DATA;
  logic        DL_WAIT;

  modport master (output DL_ACTIVE, DL_WR, DL_ADDR, DL_DATA, input DL_WAIT);
  modport slave  (input DL_ACTIVE, DL_WR, DL_ADDR, DL_DATA, output DL_WAIT);
endinterface

// File: rtl/druaga_rom_loader.sv
// Buffers the HPS ROM download stream and paces it onto the DLROM write bus,
// holding the game core in reset until the download has fully drained.
module druaga_rom_loader #(
  parameter int          FIFO_AW    = 2,
  parameter int          WR_GAP     = 2,
  parameter int          TAIL       = 16,
  parameter logic [24:0] MODEL_ADDR = 25'h0020000
) (
  input  logic                      MCLK,
  input  logic                      RESET,
  druaga_rom_loader_if.slave        dl,
  output logic                      ROMCL,
  output logic [16:0]               ROMAD,
  output logic [7:0]                ROMDT,
  output logic                      ROMEN,
  output logic [2:0]                MODEL,
  output logic                      CORE_RESET,
  output logic [15:0]               CHECKSUM,
  output logic [7:0]                DROPPED,
  output logic                      BUSY
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int GW    = (WR_GAP < 1) ? 1 : $clog2(WR_GAP + 1);
  localparam int TW    = (TAIL < 2) ? 1 : $clog2(TAIL);
  localparam logic [GW-1:0]      GAP_RELOAD = GW'(WR_GAP);
  localparam logic [TW-1:0]      TAIL_LOAD  = TW'(TAIL - 1);
  localparam logic [FIFO_AW:0]   FULL_CNT   = (FIFO_AW + 1)'(DEPTH);

  // state | meaning
  // IDLE  | no download, core released
  // LOAD  | DL_ACTIVE high, bytes arriving
  // DRAIN | source done, FIFO and last write still finishing
  // TAIL  | hold core reset TAIL more cycles after the last write
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_TAIL} state_t;
  state_t state, state_nxt;

  logic [24:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count, count_nxt;
  logic [GW-1:0]      gap_cnt;
  logic [TW-1:0]      tail_cnt;
  logic               dl_wait_q, act_q, busy_q;
  logic               accept, is_model, in_range, push, pop, drop, dl_rise;
  logic               clear_stats, tail_load;
  logic [24:0]        head;
  logic [15:0]        cks_base, cks_add;
  logic [7:0]         drp_base;

  assign accept   = dl.DL_ACTIVE & dl.DL_WR & ~dl_wait_q;
  assign is_model = (dl.DL_ADDR == MODEL_ADDR);
  assign in_range = (dl.DL_ADDR[24:17] == 8'h00);
  assign push     = accept & ~is_model & in_range & (count != FULL_CNT);
  assign drop     = accept & ~is_model & ~in_range;
  assign pop      = (count != '0) & (gap_cnt == '0);
  assign dl_rise  = dl.DL_ACTIVE & ~act_q;
  assign head     = mem[rd_ptr];

  assign count_nxt = count + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
  assign cks_base  = clear_stats ? 16'h0000 : CHECKSUM;
  assign cks_add   = pop ? {8'h00, head[7:0]} : 16'h0000;
  assign drp_base  = clear_stats ? 8'h00 : DROPPED;

  assign dl.DL_WAIT = dl_wait_q;
  assign ROMCL      = MCLK;
  assign BUSY       = busy_q;
  // busy_q is a single flop, so the IDLE transition cannot glitch this output
  assign CORE_RESET = RESET | busy_q;

  always_comb begin
    state_nxt   = state;
    clear_stats = 1'b0;
    tail_load   = 1'b0;
    case (state)
      S_IDLE:
        if (dl_rise) begin
          state_nxt   = S_LOAD;
          clear_stats = 1'b1;
        end
      S_LOAD:
        if (!dl.DL_ACTIVE) state_nxt = S_DRAIN;
      S_DRAIN:
        if (count == '0 && gap_cnt == '0 && !ROMEN) begin
          state_nxt = S_TAIL;
          tail_load = 1'b1;
        end
      S_TAIL:
        if (dl_rise) begin
          state_nxt   = S_LOAD;
          clear_stats = 1'b1;
        end else if (tail_cnt == '0) begin
          state_nxt = S_IDLE;
        end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge MCLK) begin
    if (push) mem[wr_ptr] <= {dl.DL_ADDR[16:0], dl.DL_DATA};
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dl_wait_q <= 1'b0;
      gap_cnt   <= '0;
      tail_cnt  <= '0;
      act_q     <= 1'b0;
      busy_q    <= 1'b0;
      ROMEN     <= 1'b0;
      ROMAD     <= '0;
      ROMDT     <= '0;
      MODEL     <= '0;
      CHECKSUM  <= '0;
      DROPPED   <= '0;
    end else begin
      act_q     <= dl.DL_ACTIVE;
      busy_q    <= (state_nxt != S_IDLE);
      count     <= count_nxt;
      dl_wait_q <= (count_nxt == FULL_CNT);
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);

      if (pop)                 gap_cnt <= GAP_RELOAD;
      else if (gap_cnt != '0)  gap_cnt <= gap_cnt - GW'(1);

      ROMEN <= pop;
      if (pop) begin
        ROMAD <= head[24:8];
        ROMDT <= head[7:0];
      end
      CHECKSUM <= cks_base + cks_add;
      DROPPED  <= (drop && drp_base != 8'hFF) ? drp_base + 8'd1 : drp_base;
      if (accept && is_model) MODEL <= dl.DL_DATA[2:0];

      if (tail_load)                               tail_cnt <= TAIL_LOAD;
      else if (state == S_TAIL && tail_cnt != '0)  tail_cnt <= tail_cnt - TW'(1);
    end
  end
endmodule

// File: tb/tb_druaga_rom_loader.sv
// Scoreboard bench: stimulus pushes expected ROM writes into a queue,
// a negedge monitor pops and compares every ROMEN pulse.
module tb_druaga_rom_loader;
  localparam int          WR_GAP     = 2;
  localparam int          TAIL       = 16;
  localparam logic [24:0] MODEL_ADDR = 25'h0020000;

  logic        MCLK = 1'b0;
  logic        RESET;
  logic        ROMCL, ROMEN, CORE_RESET, BUSY;
  logic [16:0] ROMAD;
  logic [7:0]  ROMDT, DROPPED;
  logic [2:0]  MODEL;
  logic [15:0] CHECKSUM;

  druaga_rom_loader_if dl_bus();

  druaga_rom_loader #(.FIFO_AW(2), .WR_GAP(WR_GAP), .TAIL(TAIL), .MODEL_ADDR(MODEL_ADDR)) dut (
    .MCLK(MCLK), .RESET(RESET), .dl(dl_bus),
    .ROMCL(ROMCL), .ROMAD(ROMAD), .ROMDT(ROMDT), .ROMEN(ROMEN),
    .MODEL(MODEL), .CORE_RESET(CORE_RESET), .CHECKSUM(CHECKSUM),
    .DROPPED(DROPPED), .BUSY(BUSY)
  );

  always #5 MCLK = ~MCLK;

  int cyc = 0;
  always @(posedge MCLK) cyc <= cyc + 1;

  int          vectors = 0, miscompares = 0;
  logic [24:0] exp_q[$];
  int          exp_sum, exp_drop;
  logic [2:0]  exp_model;
  int          pulses = 0, last_pulse_cyc = -100, acc_cyc = 0;
  int          pulse_cycs[$];
  logic        saw_wait;
  logic [24:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every write strobe must match the oldest outstanding byte
  always @(negedge MCLK) begin
    if (RESET === 1'b0 && ROMEN === 1'b1) begin
      if (last_pulse_cyc >= 0) chk("romen_spacing", 32'(cyc - last_pulse_cyc >= WR_GAP + 1), 1);
      pulses++;
      pulse_cycs.push_back(cyc);
      last_pulse_cyc = cyc;
      if (exp_q.size() == 0) chk("unexpected_romen", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("romad", 32'(ROMAD), 32'(mon_e[24:8]));
        chk("romdt", 32'(ROMDT), 32'(mon_e[7:0]));
        exp_sum = (exp_sum + int'(mon_e[7:0])) & 16'hFFFF;
      end
    end
  end

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int guard;
    guard = 0;
    dl_bus.DL_WR = 1'b1; dl_bus.DL_ADDR = a; dl_bus.DL_DATA = d;
    while (dl_bus.DL_WAIT !== 1'b0 && guard < 200) begin
      saw_wait = 1'b1;
      @(negedge MCLK);
      guard++;
    end
    if (guard >= 200) chk("dl_wait_timeout", 1, 0);
    if (a == MODEL_ADDR)         exp_model = d[2:0];
    else if (a[24:17] == 8'h00)  exp_q.push_back({a[16:0], d});
    else if (exp_drop < 255)     exp_drop++;
    @(negedge MCLK);
    acc_cyc = cyc;
  endtask

  task automatic idle_cycles(input int n);
    dl_bus.DL_WR = 1'b0;
    repeat (n) @(negedge MCLK);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((BUSY !== 1'b0 || exp_q.size() != 0) && g < 3000) begin
      @(negedge MCLK);
      g++;
    end
    if (g >= 3000) chk("idle_timeout", 1, 0);
  endtask

  task automatic start_dl();
    wait_idle();
    dl_bus.DL_ACTIVE = 1'b1;
    exp_sum  = 0;
    exp_drop = 0;
    @(negedge MCLK);
  endtask

  task automatic end_dl();
    dl_bus.DL_WR     = 1'b0;
    dl_bus.DL_ACTIVE = 1'b0;
    @(negedge MCLK);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_dl_wait"},    32'(dl_bus.DL_WAIT), 0);
    chk({tag, "_romen"},      32'(ROMEN), 0);
    chk({tag, "_busy"},       32'(BUSY), 0);
    chk({tag, "_romad"},      32'(ROMAD), 0);
    chk({tag, "_romdt"},      32'(ROMDT), 0);
    chk({tag, "_model"},      32'(MODEL), 0);
    chk({tag, "_checksum"},   32'(CHECKSUM), 0);
    chk({tag, "_dropped"},    32'(DROPPED), 0);
    chk({tag, "_core_reset"}, 32'(CORE_RESET), 1);
  endtask

  task automatic single_byte(input string tag);
    int p0;
    start_dl();
    p0 = pulses;
    send_byte(25'h0000010, 8'hA5);
    end_dl();
    wait_idle();
    chk({tag, "_pulse_count"}, 32'(pulses - p0), 1);
    chk({tag, "_latency"},     32'(last_pulse_cyc - acc_cyc), 1);
    chk({tag, "_checksum"},    32'(CHECKSUM), 32'h00A5);
    chk({tag, "_checksum_m"},  32'(CHECKSUM), 32'(exp_sum));
  endtask

  initial begin
    int p0, g, fall_cyc;
    logic prev_busy;
    logic [24:0] a;
    logic [7:0]  d;

    dl_bus.DL_ACTIVE = 1'b0; dl_bus.DL_WR = 1'b0;
    dl_bus.DL_ADDR = '0; dl_bus.DL_DATA = '0;
    RESET = 1'b0; exp_model = 3'd0; exp_sum = 0; exp_drop = 0; saw_wait = 1'b0;

    // asynchronous reset mid-cycle, checked before any clock edge
    #3 RESET = 1'b1;
    #1 check_reset_vals("reset");
    repeat (3) @(negedge MCLK);
    RESET = 1'b0;
    @(negedge MCLK);
    chk("idle_core_reset", 32'(CORE_RESET), 0);
    @(posedge MCLK); #1 chk("romcl_high", 32'(ROMCL), 1);
    @(negedge MCLK); #1 chk("romcl_low", 32'(ROMCL), 0);
    @(negedge MCLK);

    single_byte("single");

    // burst of 10 with back-pressure: writes every WR_GAP+1 cycles
    start_dl();
    p0 = pulses; saw_wait = 1'b0;
    pulse_cycs.delete();
    for (int i = 1; i <= 10; i++) send_byte(25'h0000100 + 25'(i), 8'(i));
    end_dl();
    wait_idle();
    chk("burst_saw_wait", 32'(saw_wait), 1);
    chk("burst_pulse_count", 32'(pulses - p0), 10);
    chk("burst_checksum", 32'(CHECKSUM), 32'h0037);
    for (int i = 1; i < pulse_cycs.size(); i++)
      chk("burst_spacing", 32'(pulse_cycs[i] - pulse_cycs[i-1]), WR_GAP + 1);

    // routing: MODEL capture, out-of-range drop, in-range write
    start_dl();
    p0 = pulses;
    send_byte(25'h0020000, 8'h05); idle_cycles(1);
    send_byte(25'h0030000, 8'h11); idle_cycles(1);
    send_byte(25'h0013500, 8'h0F); idle_cycles(1);
    end_dl();
    wait_idle();
    chk("route_model", 32'(MODEL), 5);
    chk("route_dropped", 32'(DROPPED), 1);
    chk("route_pulse_count", 32'(pulses - p0), 1);
    chk("route_romad", 32'(ROMAD), 32'h13500);

    // drain and tail: source stops with bytes still queued
    start_dl();
    for (int i = 0; i < 6; i++) send_byte(25'h0001000 + 25'(i), 8'h40 + 8'(i));
    end_dl();
    g = 0; prev_busy = BUSY;
    while (CORE_RESET !== 1'b0 && g < 500) begin
      prev_busy = BUSY;
      @(negedge MCLK);
      g++;
    end
    fall_cyc = cyc;
    chk("tail_timeout", 32'(g < 500), 1);
    chk("tail_all_written", 32'(exp_q.size()), 0);
    // TAIL state lasts TAIL cycles and is entered once the last write's gap has expired
    chk("tail_core_reset_delay", 32'(fall_cyc - (last_pulse_cyc + 1)), WR_GAP + TAIL);
    chk("tail_busy_before", 32'(prev_busy), 1);
    chk("tail_busy_after", 32'(BUSY), 0);
    chk("tail_checksum", 32'(CHECKSUM), 32'(exp_sum));

    // reset with bytes still queued: pending writes are lost
    start_dl();
    for (int i = 0; i < 4; i++) send_byte(25'h0002000 + 25'(i), 8'h80 + 8'(i));
    @(posedge MCLK);
    #3 RESET = 1'b1;
    dl_bus.DL_ACTIVE = 1'b0; dl_bus.DL_WR = 1'b0;
    exp_q.delete(); exp_model = 3'd0; last_pulse_cyc = -100;
    #1 check_reset_vals("midreset");
    repeat (2) @(negedge MCLK);
    RESET = 1'b0;
    p0 = pulses;
    repeat (10) @(negedge MCLK);
    chk("midreset_no_romen", 32'(pulses - p0), 0);
    chk("midreset_dl_wait", 32'(dl_bus.DL_WAIT), 0);
    chk("midreset_busy", 32'(BUSY), 0);
    single_byte("after_reset");

    // randomized mix of in-range, MODEL and out-of-range bytes
    start_dl();
    for (int i = 0; i < 60; i++) begin
      g = $urandom_range(0, 9);
      if (g < 7)      a = {8'h00, 17'($urandom)};
      else if (g < 8) a = MODEL_ADDR;
      else            a = {8'($urandom_range(2, 255)), 17'($urandom)};
      d = 8'($urandom);
      send_byte(a, d);
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
    end
    end_dl();
    wait_idle();
    chk("rand_checksum", 32'(CHECKSUM), 32'(exp_sum));
    chk("rand_dropped", 32'(DROPPED), 32'(exp_drop));
    chk("rand_model", 32'(MODEL), 32'(exp_model));

    // DROPPED saturates at 255
    start_dl();
    for (int i = 0; i < 260; i++) send_byte(25'h1000000 + 25'(i), 8'(i));
    end_dl();
    wait_idle();
    chk("sat_dropped", 32'(DROPPED), 255);
    chk("sat_dropped_m", 32'(DROPPED), 32'(exp_drop));
    chk("sat_checksum", 32'(CHECKSUM), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
